// File: rtl/regfile_pkg.sv
// Shared defaults and helpers for the multi-port register file slice.
// Optional write-through forwarding is enabled by defining REGFILE_BYPASS_EN.
package regfile_pkg;

  localparam int unsigned DATA_W_DEF = 19;
  localparam int unsigned ADDR_W_DEF = 4;

  function automatic int unsigned num_regs(input int unsigned addr_w);
    return 32'd1 << addr_w;
  endfunction

  localparam int unsigned NUM_REGS_DEF = num_regs(ADDR_W_DEF);

  typedef logic [ADDR_W_DEF-1:0] reg_addr_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits: set on reservation, cleared by either writeback port.
// A reservation and a writeback to the same register in one cycle leaves it busy.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter bit          R0_ZERO  = 1'b1,
  localparam int unsigned NUM_REGS = num_regs(ADDR_W)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                set_en,
  input  logic [ADDR_W-1:0]   set_addr,
  input  logic                clr_a_en,
  input  logic [ADDR_W-1:0]   clr_a_addr,
  input  logic                clr_b_en,
  input  logic [ADDR_W-1:0]   clr_b_addr,
  output logic [NUM_REGS-1:0] busy
);

  logic [NUM_REGS-1:0] busy_d;

  always_comb begin
    busy_d = busy;
    for (int unsigned r = 0; r < NUM_REGS; r++) begin
      if ((clr_a_en && clr_a_addr == ADDR_W'(r)) ||
          (clr_b_en && clr_b_addr == ADDR_W'(r)))
        busy_d[r] = 1'b0;
      // Applied after the clear so a new owner keeps the register busy.
      if (set_en && set_addr == ADDR_W'(r))
        busy_d[r] = 1'b1;
    end
    if (R0_ZERO)
      busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      busy <= '0;
    else
      busy <= busy_d;
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with two writeback ports and a busy scoreboard.
// Define REGFILE_BYPASS_EN for same-cycle write-through forwarding on the read ports.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned NUM_RD  = 2,
  parameter bit          R0_ZERO = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wa_en,
  input  logic [ADDR_W-1:0]        wa_addr,
  input  logic [DATA_W-1:0]        wa_data,
  input  logic                     wb_en,
  input  logic [ADDR_W-1:0]        wb_addr,
  input  logic [DATA_W-1:0]        wb_data,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr,
  output logic                     wr_conflict
);

  localparam int unsigned NUM_REGS = num_regs(ADDR_W);

  logic [DATA_W-1:0]   mem [NUM_REGS];
  logic [NUM_REGS-1:0] busy;
  logic                conflict_d;

  logic [ADDR_W-1:0]   ra;
  logic [DATA_W-1:0]   rdat;
  logic                rbsy;
`ifdef REGFILE_BYPASS_EN
  logic                wa_hit;
  logic                wb_hit;
  logic                rsv_hit;
`endif

  // Port B wins a same-address collision; r0 is never stored when hardwired.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned r = 0; r < NUM_REGS; r++)
        mem[r] <= '0;
    end else begin
      for (int unsigned r = 0; r < NUM_REGS; r++) begin
        if (!(R0_ZERO && r == 0)) begin
          if (wb_en && wb_addr == ADDR_W'(r))
            mem[r] <= wb_data;
          else if (wa_en && wa_addr == ADDR_W'(r))
            mem[r] <= wa_data;
        end
      end
    end
  end

  assign conflict_d = wa_en && wb_en && (wa_addr == wb_addr) &&
                      !(R0_ZERO && wa_addr == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      wr_conflict <= 1'b0;
    else
      wr_conflict <= conflict_d;
  end

  regfile_scoreboard #(
    .ADDR_W  (ADDR_W),
    .R0_ZERO (R0_ZERO)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .set_en     (rsv_en),
    .set_addr   (rsv_addr),
    .clr_a_en   (wa_en),
    .clr_a_addr (wa_addr),
    .clr_b_en   (wb_en),
    .clr_b_addr (wb_addr),
    .busy       (busy)
  );

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    ra      = '0;
    rdat    = '0;
    rbsy    = 1'b0;
`ifdef REGFILE_BYPASS_EN
    wa_hit  = 1'b0;
    wb_hit  = 1'b0;
    rsv_hit = 1'b0;
`endif
    for (int unsigned i = 0; i < NUM_RD; i++) begin
      ra   = rd_addr[i*ADDR_W +: ADDR_W];
      rdat = mem[ra];
      rbsy = busy[ra];
`ifdef REGFILE_BYPASS_EN
      // Writes held off by reset are not forwarded, matching the array.
      wa_hit  = rst && wa_en && (wa_addr == ra);
      wb_hit  = rst && wb_en && (wb_addr == ra);
      rsv_hit = rsv_en && (rsv_addr == ra);
      if (wb_hit)
        rdat = wb_data;
      else if (wa_hit)
        rdat = wa_data;
      if ((wa_hit || wb_hit) && !rsv_hit)
        rbsy = 1'b0;
`endif
      if (R0_ZERO && ra == '0) begin
        rdat = '0;
        rbsy = 1'b0;
      end
      rd_data[i*DATA_W +: DATA_W] = rdat;
      rd_busy[i]                  = rbsy;
    end
  end

endmodule
